// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART byte receiver.
// Holds the receive FSM state type, the data-bit counter width and a
// helper that sizes the baud counter for a given clocks-per-bit divisor.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam int BIT_CNT_W = 4;

    // Width of a counter that must hold values 0 .. clkDiv-1.
    function automatic int baudCntWidth(input int clkDiv);
        return (clkDiv > 2) ? $clog2(clkDiv) : 1;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Pointer-based byte FIFO with first-word-fall-through read.
// The head entry is always presented on head_o straight from the storage
// registers, so a pop at a clock edge shows the next head in the following
// cycle. A push while full is ignored unless a pop happens in the same
// cycle, in which case both take effect and the count is unchanged.
//
// Ports:
//   clock, resetb  system clock, asynchronous active-low reset
//   push_i, data_i write request and byte
//   pop_i          remove head byte (ignored when empty)
//   head_o         current head byte
//   count_o        number of stored bytes
//   full_o/empty_o fill status
module rx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetb,
    input  logic                       push_i,
    input  logic [7:0]                 data_i,
    input  logic                       pop_i,
    output logic [7:0]                 head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          doPush;
    logic          doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Decide which requests actually take effect. When full, the slot the
    // writer targets is the head being popped, so a simultaneous push/pop
    // safely reuses it.
    always_comb begin
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage clears on reset so the head
    // reads zero until the first byte arrives.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_bytes.sv
// 8N1 UART receiver feeding a small byte FIFO.
// Listens to the management UART transmit line, recovers each byte,
// queues it, and raises sticky flags for framing errors and overflow.
//
// Ports:
//   clock, resetb  system clock, asynchronous active-low reset
//   rx             serial input, idle high, asynchronous to clock
//   rd_en          pop the head byte (ignored when rd_valid=0)
//   rd_data        head byte, valid while rd_valid=1
//   rd_valid       FIFO not empty
//   fifo_count     number of stored bytes
//   frame_err      sticky: stop bit sampled low
//   overflow       sticky: byte arrived while FIFO full
//   err_clr        clear both sticky flags
module uart_rx_bytes
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   rx,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   err_clr
);

    localparam int CNT_W = baudCntWidth(CLK_DIV);
    localparam logic [CNT_W-1:0]     HALF_LAST     = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]     BIT_LAST      = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(7);

    rx_state_t            state_q, state_d;
    logic                 rxMeta_q;
    logic                 rxSync_q;
    logic [CNT_W-1:0]     baudCnt_q, baudCnt_d;
    logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 frameErr_q, frameErr_d;
    logic                 overflow_q, overflow_d;
    logic                 pushByte;
    logic                 frameEvent;
    logic                 overflowEvent;
    logic                 fifoFull;
    logic                 fifoEmpty;

    // Receive FSM. The baud counter free-runs in every sampling state and
    // is cleared whenever a sample is taken, so START samples mid start bit
    // and every later sample lands one full bit period after the previous.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q + 1'b1;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        pushByte   = 1'b0;
        frameEvent = 1'b0;
        case (state_q)
            RX_IDLE: begin
                baudCnt_d = '0;
                bitCnt_d  = '0;
                if (!rxSync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (baudCnt_q == HALF_LAST) begin
                    baudCnt_d = '0;
                    if (rxSync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    shift_d   = {rxSync_q, shift_q[7:1]};
                    bitCnt_d  = bitCnt_q + 1'b1;
                    if (bitCnt_q == LAST_DATA_BIT) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baudCnt_q == BIT_LAST) begin
                    baudCnt_d = '0;
                    if (rxSync_q) begin
                        pushByte = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        frameEvent = 1'b1;
                        state_d    = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                baudCnt_d = '0;
                if (rxSync_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Sticky flags: a new event in the same cycle as err_clr keeps the flag
    // set. A full FIFO always has a head, so rd_en alone means a real pop.
    always_comb begin
        overflowEvent = pushByte && fifoFull && !rd_en;
        frameErr_d    = (frameErr_q && !err_clr) || frameEvent;
        overflow_d    = (overflow_q && !err_clr) || overflowEvent;
    end

    // Synchronizer, FSM state, counters, shift register and flag registers.
    // The synchronizer resets to the idle-high line level so reset never
    // looks like a start bit.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            state_q    <= RX_IDLE;
            baudCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rxMeta_q   <= rx;
            rxSync_q   <= rxMeta_q;
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            frameErr_q <= frameErr_d;
            overflow_q <= overflow_d;
        end
    end

    rx_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .push_i  (pushByte),
        .data_i  (shift_q),
        .pop_i   (rd_en),
        .head_o  (rd_data),
        .count_o (fifo_count),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign rd_valid  = !fifoEmpty;
    assign frame_err = frameErr_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_bytes.sv
// Self-checking bench for uart_rx_bytes with CLK_DIV=16, DEPTH=4.
// Frames are driven bit by bit on the falling clock edge; a table of
// frames lists the expected count and flags after each one, and a queue
// of expected bytes is compared against rd_data whenever a byte is popped.
module tb_uart_rx_bytes;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       clock;
    logic       resetb;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overflow;
    logic       err_clr;

    int errors = 0;
    int checks = 0;

    logic [7:0] expQ[$];

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       popAtPush;
        logic [2:0] expCount;
        logic       expFrameErr;
        logic       expOverflow;
    } vec_t;

    vec_t vecs[17];

    uart_rx_bytes #(
        .CLK_DIV(CLK_DIV),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clr   (err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: count it, and report it if it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive a full frame starting at a falling edge. Optionally pulse rd_en
    // exactly on the edge that pushes the byte, and optionally check that
    // rd_valid rises on exactly that edge.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit,
                             input bit popAtPush, input bit checkTiming);
        for (int t = 0; t < FRAME; t++) begin
            int b;
            b = t / CLK_DIV;
            if (checkTiming && t == 152) checkOutput("rd_valid before stop sample", rd_valid, 0);
            if (checkTiming && t == 155) checkOutput("rd_valid after stop sample", rd_valid, 1);
            if (popAtPush && t == 154) begin
                if (expQ.size() == 0) begin
                    checkOutput("head present for push+pop", 0, 1);
                end else begin
                    checkOutput("push+pop head data", rd_data, expQ.pop_front());
                end
                rd_en = 1'b1;
            end
            if (popAtPush && t == 155) rd_en = 1'b0;
            if (b == 0)      rx = 1'b0;
            else if (b == 9) rx = stopBit;
            else             rx = data[b-1];
            @(negedge clock);
        end
    endtask

    // Send one table frame, update the scoreboard, check count and flags.
    task automatic applyStimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        sendFrame(v.data, v.stopBit, v.popAtPush, idx == 0);
        if (v.stopBit && (v.popAtPush || expQ.size() < DEPTH)) expQ.push_back(v.data);
        checkOutput($sformatf("vec%0d fifo_count", idx), fifo_count, v.expCount);
        checkOutput($sformatf("vec%0d frame_err", idx), frame_err, v.expFrameErr);
        checkOutput($sformatf("vec%0d overflow", idx), overflow, v.expOverflow);
        checkOutput($sformatf("vec%0d rd_valid", idx), rd_valid, v.expCount != 0);
    endtask

    // Pop one byte and compare it with the oldest expected byte.
    task automatic popCheck();
        checkOutput("rd_valid before pop", rd_valid, 1);
        if (expQ.size() == 0) begin
            checkOutput("scoreboard has byte to pop", 0, 1);
        end else begin
            checkOutput("pop data", rd_data, expQ.pop_front());
        end
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rd_valid"}, rd_valid, 0);
        checkOutput({tag, " fifo_count"}, fifo_count, 0);
        checkOutput({tag, " rd_data"}, rd_data, 0);
        checkOutput({tag, " frame_err"}, frame_err, 0);
        checkOutput({tag, " overflow"}, overflow, 0);
    endtask

    initial begin
        //           data   stop  popP  cnt   fe    ov
        vecs[0]  = '{8'hA5, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{8'h3C, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[2]  = '{8'h55, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[3]  = '{8'h12, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[4]  = '{8'h01, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[5]  = '{8'h02, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[6]  = '{8'h03, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[7]  = '{8'h04, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[8]  = '{8'h05, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
        vecs[9]  = '{8'h10, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{8'h11, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[11] = '{8'h12, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
        vecs[12] = '{8'h13, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[13] = '{8'h77, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
        vecs[14] = '{8'h9A, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[15] = '{8'h66, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[16] = '{8'hC3, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};

        resetb  = 1'b0;
        rx      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        idle(3);
        checkResetValues("reset");
        resetb = 1'b1;
        idle(5);

        // Two back-to-back frames, then drain in order.
        applyStimulus(0);
        applyStimulus(1);
        popCheck();
        popCheck();
        checkOutput("empty after drain", rd_valid, 0);

        // Short low glitch is a false start.
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        checkOutput("false start fifo_count", fifo_count, 0);
        checkOutput("false start frame_err", frame_err, 0);
        checkOutput("false start overflow", overflow, 0);

        // Framing error followed by a held-low break, then recovery.
        applyStimulus(2);
        idle(40);
        checkOutput("break fifo_count", fifo_count, 0);
        checkOutput("break frame_err", frame_err, 1);
        rx = 1'b1;
        idle(20);
        applyStimulus(3);
        popCheck();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        checkOutput("frame_err cleared", frame_err, 0);

        // Five frames into a four-entry FIFO.
        for (int i = 4; i <= 8; i++) applyStimulus(i);
        for (int i = 0; i < 4; i++) popCheck();
        checkOutput("empty after overflow drain", rd_valid, 0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        checkOutput("overflow cleared", overflow, 0);

        // Fill, then pop on the very edge that pushes 0x77.
        for (int i = 9; i <= 13; i++) applyStimulus(i);
        for (int i = 0; i < 4; i++) popCheck();
        checkOutput("empty after push+pop drain", rd_valid, 0);

        // Stored byte and error flag, then reset during data bit 4.
        applyStimulus(14);
        applyStimulus(15);
        rx = 1'b1;
        idle(20);
        begin
            logic [7:0] partial;
            partial = 8'hC3;
            for (int t = 0; t < 5 * CLK_DIV + CLK_DIV / 2; t++) begin
                int b;
                b = t / CLK_DIV;
                rx = (b == 0) ? 1'b0 : partial[b-1];
                @(negedge clock);
            end
        end
        resetb = 1'b0;
        rx     = 1'b1;
        idle(2);
        checkResetValues("mid-frame reset");
        expQ.delete();
        resetb = 1'b1;
        idle(10);
        checkResetValues("after reset release");
        applyStimulus(16);
        popCheck();
        checkOutput("empty at end", rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
